// File: rtl/auth_pkg.sv
// Shared definitions for the certificate responder: FSM encoding, message
// codes, error codes and protocol size limits.
package auth_pkg;

   typedef enum logic [3:0] {
      IDLE, RX_HDR, RX_BODY, CHECK, TX_HDR, RD_REQ, RD_WAIT, TX_DATA, TX_ERR
   } state_t;

   localparam logic [7:0] MSG_GET_DIGESTS     = 8'h81;
   localparam logic [7:0] MSG_GET_CERTIFICATE = 8'h82;
   localparam logic [7:0] MSG_CHALLENGE       = 8'h83;
   localparam logic [7:0] MSG_CERTIFICATE     = 8'h02;
   localparam logic [7:0] MSG_ERROR           = 8'h7F;

   localparam logic [7:0] ERR_INVALID_REQUEST     = 8'h01;
   localparam logic [7:0] ERR_UNSUPPORTED_REQUEST = 8'h02;

   localparam logic [7:0] AUTH_VERSION = 8'h01;
   localparam logic [7:0] REQ_BYTES    = 8'd8;

   localparam int MAX_LEAF_CERT_SIZE         = 640;
   localparam int MAX_INTERMEDIATE_CERT_SIZE = 512;
   localparam int MAX_ACD_SIZE               = 128;
   localparam int MAX_CERT_CHAIN_SIZE        = 4096;

   function automatic logic [16:0] min17(input logic [16:0] a, input logic [16:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/auth_cert_responder_if.sv
// Byte-stream request/response channel between a requester and the responder.
interface auth_cert_responder_if;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_last;
   logic       rx_ready;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       tx_ready;

   modport master (
      output rx_valid, rx_data, rx_last, tx_ready,
      input  rx_ready, tx_valid, tx_data, tx_last
   );

   modport slave (
      input  rx_valid, rx_data, rx_last, tx_ready,
      output rx_ready, tx_valid, tx_data, tx_last
   );
endinterface

// File: rtl/auth_req_parser.sv
// Counts request bytes and captures header fields by byte position.
module auth_req_parser (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        fire,
   input  logic [7:0]  data,
   output logic [7:0]  version,
   output logic [7:0]  msg_type,
   output logic [7:0]  slot,
   output logic [15:0] offset,
   output logic [15:0] length,
   output logic [7:0]  byte_cnt
);

   always_ff @(posedge clk) begin
      if (reset) begin
         version  <= '0;
         msg_type <= '0;
         slot     <= '0;
         offset   <= '0;
         length   <= '0;
         byte_cnt <= '0;
      end else if (clear) begin
         byte_cnt <= '0;
      end else if (fire) begin
         // Saturate so an oversized request can never wrap back to a count of 8.
         if (byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 8'd1;
         case (byte_cnt)
            8'd0:    version       <= data;
            8'd1:    msg_type      <= data;
            8'd2:    slot          <= data;
            8'd4:    offset[7:0]   <= data;
            8'd5:    offset[15:8]  <= data;
            8'd6:    length[7:0]   <= data;
            8'd7:    length[15:8]  <= data;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/auth_cert_responder.sv
// GET_CERTIFICATE responder: parses an 8-byte request, validates it and
// streams a header plus a clipped window of the certificate memory.
module auth_cert_responder
   import auth_pkg::*;
#(
   parameter int MAX_CHAIN = 4096,
   parameter int ADDR_W    = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   auth_cert_responder_if.slave  bus,
   input  logic [12:0]           chain_len,
   output logic                  cert_rd_en,
   output logic [ADDR_W-1:0]     cert_addr,
   input  logic [7:0]            cert_rd_data
);

   state_t      state;
   logic        rx_ready, tx_valid, tx_last;
   logic [7:0]  tx_data;
   logic [1:0]  hdr_idx;
   logic [16:0] data_idx, eff_len;
   logic [12:0] chain_q;
   logic [7:0]  err_code;

   logic [7:0]  version, msg_type, slot, byte_cnt;
   logic [15:0] offset, length;
   logic        rx_fire, tx_fire, parse_clr, offset_bad;
   logic [16:0] remain, eff_calc;

   assign bus.rx_ready = rx_ready;
   assign bus.tx_valid = tx_valid;
   assign bus.tx_data  = tx_data;
   assign bus.tx_last  = tx_last;

   assign rx_fire   = bus.rx_valid && rx_ready;
   assign tx_fire   = tx_valid && bus.tx_ready;
   assign parse_clr = (state == CHECK);

   auth_req_parser u_parser (
      .clk      (clk),
      .reset    (reset),
      .clear    (parse_clr),
      .fire     (rx_fire),
      .data     (bus.rx_data),
      .version  (version),
      .msg_type (msg_type),
      .slot     (slot),
      .offset   (offset),
      .length   (length),
      .byte_cnt (byte_cnt)
   );

   // 17-bit so chain_len - offset and a 16-bit length compare without wrap.
   assign offset_bad = ({1'b0, offset} >= {4'd0, chain_q});
   assign remain     = {4'd0, chain_q} - {1'b0, offset};
   assign eff_calc   = min17({1'b0, length}, remain);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         rx_ready   <= 1'b0;
         tx_valid   <= 1'b0;
         tx_last    <= 1'b0;
         tx_data    <= 8'h00;
         cert_rd_en <= 1'b0;
         cert_addr  <= '0;
         hdr_idx    <= '0;
         data_idx   <= '0;
         eff_len    <= '0;
         chain_q    <= '0;
         err_code   <= '0;
      end else begin
         case (state)
            IDLE, RX_HDR, RX_BODY: begin
               rx_ready <= 1'b1;
               if (rx_fire) begin
                  if (bus.rx_last) begin
                     state    <= CHECK;
                     rx_ready <= 1'b0;
                     chain_q  <= (chain_len > 13'(MAX_CHAIN)) ? 13'(MAX_CHAIN) : chain_len;
                  end else if (state == IDLE) begin
                     state <= RX_HDR;
                  end else if (state == RX_HDR && byte_cnt == 8'd3) begin
                     state <= RX_BODY;
                  end
               end
            end

            CHECK: begin
               hdr_idx  <= '0;
               data_idx <= '0;
               tx_valid <= 1'b1;
               tx_data  <= AUTH_VERSION;
               tx_last  <= 1'b0;
               if (version != AUTH_VERSION || byte_cnt != REQ_BYTES) begin
                  err_code <= ERR_INVALID_REQUEST;
                  state    <= TX_ERR;
               end else if (msg_type != MSG_GET_CERTIFICATE) begin
                  err_code <= ERR_UNSUPPORTED_REQUEST;
                  state    <= TX_ERR;
               end else if (offset_bad) begin
                  err_code <= ERR_INVALID_REQUEST;
                  state    <= TX_ERR;
               end else begin
                  eff_len <= eff_calc;
                  state   <= TX_HDR;
               end
            end

            TX_HDR: if (tx_fire) begin
               hdr_idx <= hdr_idx + 2'd1;
               case (hdr_idx)
                  2'd0: tx_data <= MSG_CERTIFICATE;
                  2'd1: tx_data <= slot;
                  2'd2: begin
                     tx_data <= 8'h00;
                     tx_last <= (eff_len == 17'd0);
                  end
                  default: begin
                     tx_valid <= 1'b0;
                     tx_last  <= 1'b0;
                     if (eff_len == 17'd0) begin
                        state    <= IDLE;
                        rx_ready <= 1'b1;
                     end else begin
                        state      <= RD_REQ;
                        cert_rd_en <= 1'b1;
                        cert_addr  <= ADDR_W'(offset);
                     end
                  end
               endcase
            end

            TX_ERR: if (tx_fire) begin
               hdr_idx <= hdr_idx + 2'd1;
               case (hdr_idx)
                  2'd0: tx_data <= MSG_ERROR;
                  2'd1: tx_data <= err_code;
                  2'd2: begin
                     tx_data <= 8'h00;
                     tx_last <= 1'b1;
                  end
                  default: begin
                     tx_valid <= 1'b0;
                     tx_last  <= 1'b0;
                     state    <= IDLE;
                     rx_ready <= 1'b1;
                  end
               endcase
            end

            RD_REQ: begin
               cert_rd_en <= 1'b0;
               state      <= RD_WAIT;
            end

            RD_WAIT: begin
               tx_data  <= cert_rd_data;
               tx_valid <= 1'b1;
               tx_last  <= (data_idx == eff_len - 17'd1);
               state    <= TX_DATA;
            end

            TX_DATA: if (tx_fire) begin
               tx_valid <= 1'b0;
               tx_last  <= 1'b0;
               if (tx_last) begin
                  state    <= IDLE;
                  rx_ready <= 1'b1;
               end else begin
                  data_idx   <= data_idx + 17'd1;
                  cert_rd_en <= 1'b1;
                  cert_addr  <= ADDR_W'({1'b0, offset} + data_idx + 17'd1);
                  state      <= RD_REQ;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
